sram_resp: RTL and testbench
============================

SRAM_RESP -- requirements
Module: sram_resp

Interface
REQ-001 SHALL expose parameter ADDR_W, default 10, meaning implemented word-address bits (depth 2^ADDR_W x 16).
REQ-002 SHALL expose parameter INIT_VAL, default 16'h0000, meaning the reset value of every memory word.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 address  input  20  word address from the initiator.
REQ-006 CE  input  1  chip enable, active-low.
REQ-007 OE  input  1  output enable, active-low.
REQ-008 WE  input  1  write enable, active-low.
REQ-009 UB  input  1  upper-byte lane enable (bits 15:8), active-low.
REQ-010 LB  input  1  lower-byte lane enable (bits 7:0), active-low.
REQ-011 data  inout  16  shared data bus; driven only in the drive state, 16'bZ otherwise.
REQ-012 wr_cnt  output  16  saturating count of committed writes.
REQ-013 rd_cnt  output  16  saturating count of completed read drives.
REQ-014 addr_err  output  1  sticky flag: an access hit an address at or above 2^ADDR_W.

Function
REQ-015 SHALL register CE, OE, WE, UB, LB, address and data once per cycle; all decisions SHALL use the registered copies.
REQ-016 SHALL implement FSM states IDLE, WRITE, TURN, DRIVE.
REQ-017 IDLE -> WRITE when the sampled values are CE=0 and WE=0, regardless of OE; write takes priority.
REQ-018 IDLE -> TURN when the sampled values are CE=0, WE=1 and OE=0.
REQ-019 WRITE SHALL commit the sampled data to mem[address] for each enabled byte lane only, increment wr_cnt, then return to IDLE; total latency is 2 cycles from strobe to memory update.
REQ-020 A write with UB=1 and LB=1 SHALL leave memory unchanged but still increment wr_cnt.
REQ-021 TURN SHALL latch mem[address] into the read register and keep data at Z.
REQ-022 DRIVE SHALL drive the read register onto data while the sampled CE=0 and OE=0 and WE=1 hold.
REQ-023 DRIVE SHALL increment rd_cnt once on entry.
REQ-024 If the sampled address changes during DRIVE, the block SHALL go back to TURN and re-fetch.
REQ-025 DRIVE -> IDLE when the sampled CE=1 or OE=1; data SHALL be Z in the same cycle the state leaves DRIVE.
REQ-026 DRIVE -> WRITE when the sampled WE=0; data SHALL be released before the write commit.
REQ-027 Byte lanes SHALL not mask reads: all 16 bits are driven.
REQ-028 An address with any of bits 19:ADDR_W set SHALL drop the write, read as 16'h0000, and set addr_err.
REQ-029 wr_cnt and rd_cnt SHALL hold at 16'hFFFF, with no wrap.

Reset
REQ-030 Asserting reset_n low SHALL immediately force state IDLE, data Z, wr_cnt=0, rd_cnt=0, addr_err=0, and every memory word to INIT_VAL.
REQ-031 Reset asserted mid-WRITE SHALL discard the pending commit; reset asserted mid-DRIVE SHALL release the bus asynchronously.
REQ-032 After reset_n deasserts, the first sampled strobe SHALL be acted on normally, with no extra wait cycle.

Configuration
REQ-033 Macro SRAM_RESP_TURNAROUND_EN defined: TURN is a distinct state, and read latency is 2 cycles from strobe sample to first drive.
REQ-034 Macro SRAM_RESP_TURNAROUND_EN undefined: TURN is merged into IDLE -> DRIVE, with the read register loaded on the same edge; read latency is 1 cycle and all other behaviour is unchanged.

Verification
REQ-035 Reset, then CE=0 WE=0 UB=0 LB=0 address=5 data=16'hA5C3 for 1 cycle, then a read at address 5 -> data=16'hA5C3 during DRIVE; wr_cnt=1, rd_cnt=1.
REQ-036 mem[7]=16'h1234, then write 16'hFFFF to address 7 with UB=1 LB=0, then read -> 16'h12FF.
REQ-037 CE=0 OE=0 WE=0 with address=3 and data=16'h0042 -> memory written, data bus never driven by the block, rd_cnt unchanged.
REQ-038 Read address 2^ADDR_W+1 -> data=16'h0000 and addr_err=1; a following valid read leaves addr_err=1.
REQ-039 Drive reset_n low during DRIVE -> data=Z before the next clk edge; all counters are 0.
REQ-040 Preset wr_cnt=16'hFFFE, then issue 3 writes -> wr_cnt=16'hFFFF.

Source files
------------

// File: rtl/sram_resp.sv
// Registered-strobe SRAM responder: 2^ADDR_W x 16 memory behind an async-SRAM style pin interface.
// Define SRAM_RESP_TURNAROUND_EN for a distinct TURN state (2-cycle read latency); the default build reads in 1 cycle.
module sram_resp #(
  parameter int          ADDR_W   = 10,
  parameter logic [15:0] INIT_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [19:0] address,
  input  logic        CE,
  input  logic        OE,
  input  logic        WE,
  input  logic        UB,
  input  logic        LB,
  inout  wire  [15:0] data,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt,
  output logic        addr_err
);

  typedef enum logic [1:0] {IDLE, WRITE, TURN, DRIVE} state_e;

  localparam int DEPTH = 2 ** ADDR_W;

  // Sampled pin copies; strobes reset to their inactive (high) level.
  logic              ce_q, oe_q, we_q, ub_q, lb_q;
  logic [19:0]       addr_q;
  logic [15:0]       din_q;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              wr_ub_q, wr_ub_d;
  logic              wr_lb_q, wr_lb_d;
  logic              wr_oob_q, wr_oob_d;
  logic [15:0]       rd_q, rd_d;
  logic [19:0]       rd_addr_q, rd_addr_d;
  logic [15:0]       wr_cnt_q, wr_cnt_d;
  logic [15:0]       rd_cnt_q, rd_cnt_d;
  logic              addr_err_q, addr_err_d;

  logic [15:0]       mem_q [DEPTH];

  logic              addr_oob;
  logic [15:0]       rd_fetch;
  logic              start_write;
  logic              fetch;
  logic              commit;
  logic              drive_en;

  assign addr_oob = (addr_q >> ADDR_W) != '0;
  assign rd_fetch = addr_oob ? 16'h0000 : mem_q[addr_q[ADDR_W-1:0]];

  // Bus is released as soon as any sampled qualifier drops, not a cycle later.
  assign drive_en = (state_q == DRIVE) && !ce_q && !oe_q && we_q && (addr_q == rd_addr_q);
  assign data     = drive_en ? rd_q : 16'hzzzz;

  assign wr_cnt   = wr_cnt_q;
  assign rd_cnt   = rd_cnt_q;
  assign addr_err = addr_err_q;

  // NOTE: non-blocking assignments in every clocked block so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_q   <= 1'b1;
      oe_q   <= 1'b1;
      we_q   <= 1'b1;
      ub_q   <= 1'b1;
      lb_q   <= 1'b1;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      ce_q   <= CE;
      oe_q   <= OE;
      we_q   <= WE;
      ub_q   <= UB;
      lb_q   <= LB;
      addr_q <= address;
      din_q  <= data;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_ub_d     = wr_ub_q;
    wr_lb_d     = wr_lb_q;
    wr_oob_d    = wr_oob_q;
    rd_d        = rd_q;
    rd_addr_d   = rd_addr_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    addr_err_d  = addr_err_q;
    start_write = 1'b0;
    fetch       = 1'b0;
    commit      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!ce_q && !we_q) begin
          start_write = 1'b1;
        end else if (!ce_q && !oe_q) begin
`ifdef SRAM_RESP_TURNAROUND_EN
          state_d = TURN;
`else
          fetch = 1'b1;
`endif
        end
      end
      WRITE: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      TURN: begin
        if (ce_q || oe_q)  state_d     = IDLE;
        else if (!we_q)    start_write = 1'b1;
        else               fetch       = 1'b1;
      end
      DRIVE: begin
        if (ce_q)                         state_d     = IDLE;
        else if (!we_q)                   start_write = 1'b1;
        else if (oe_q)                    state_d     = IDLE;
        else if (addr_q != rd_addr_q) begin
`ifdef SRAM_RESP_TURNAROUND_EN
          state_d = TURN;
`else
          fetch = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_write) begin
      state_d    = WRITE;
      wr_addr_d  = addr_q[ADDR_W-1:0];
      wr_data_d  = din_q;
      wr_ub_d    = ub_q;
      wr_lb_d    = lb_q;
      wr_oob_d   = addr_oob;
      addr_err_d = addr_err_q | addr_oob;
    end

    // Each (re)entry into DRIVE is one completed read drive.
    if (fetch) begin
      state_d    = DRIVE;
      rd_d       = rd_fetch;
      rd_addr_d  = addr_q;
      addr_err_d = addr_err_q | addr_oob;
      if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
    end

    if (commit && !wr_oob_q && (wr_cnt_q != 16'hFFFF)) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_ub_q    <= 1'b1;
      wr_lb_q    <= 1'b1;
      wr_oob_q   <= 1'b0;
      rd_q       <= '0;
      rd_addr_q  <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_ub_q    <= wr_ub_d;
      wr_lb_q    <= wr_lb_d;
      wr_oob_q   <= wr_oob_d;
      rd_q       <= rd_d;
      rd_addr_q  <= rd_addr_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  // NOTE: the array has an async reset to INIT_VAL, so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_VAL;
    end else if (commit && !wr_oob_q) begin
      if (!wr_ub_q) mem_q[wr_addr_q][15:8] <= wr_data_q[15:8];
      if (!wr_lb_q) mem_q[wr_addr_q][7:0]  <= wr_data_q[7:0];
    end
  end

endmodule

// File: tb/tb_sram_resp.sv
// Directed bench for sram_resp: writes, byte lanes, reads, bus release, range errors, saturation and reset.
// The bus carries pull-ups, so a released bus reads 16'hFFFF.
module tb_sram_resp;

`ifdef SRAM_RESP_TURNAROUND_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [15:0] RELEASED = 16'hFFFF;

  logic        clk;
  logic        reset_n;
  logic [19:0] address;
  logic        CE, OE, WE, UB, LB;
  logic [15:0] tb_data;
  logic        tb_drive;
  wire  [15:0] data_bus;
  logic [15:0] wr_cnt, rd_cnt;
  logic        addr_err;

  int n_total = 0;
  int n_bad   = 0;

  sram_resp #(.ADDR_W(10), .INIT_VAL(16'h0000)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .address  (address),
    .CE       (CE),
    .OE       (OE),
    .WE       (WE),
    .UB       (UB),
    .LB       (LB),
    .data     (data_bus),
    .wr_cnt   (wr_cnt),
    .rd_cnt   (rd_cnt),
    .addr_err (addr_err)
  );

  assign data_bus = tb_drive ? tb_data : 16'hzzzz;

  for (genvar i = 0; i < 16; i++) begin : g_pull
    pullup (data_bus[i]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic do_write(input logic [19:0] a, input logic [15:0] v, input logic ub, input logic lb);
    address = a; CE = 1'b0; WE = 1'b0; OE = 1'b1; UB = ub; LB = lb;
    tb_data = v; tb_drive = 1'b1;
    @(negedge clk);
    CE = 1'b1; WE = 1'b1; UB = 1'b0; LB = 1'b0; tb_drive = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_read(input logic [19:0] a, output int lat);
    address = a; CE = 1'b0; OE = 1'b0; WE = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (data_bus !== RELEASED) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_read(input string tag, input logic [19:0] a, input logic [15:0] exp);
    int lat;
    start_read(a, lat);
    check({tag, "_lat"}, lat, LAT + 1);
    check({tag, "_val"}, data_bus, exp);
    CE = 1'b1; OE = 1'b1;
    @(negedge clk);
    check({tag, "_rel"}, data_bus, RELEASED);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic seen_drive;
    reset_n = 1'b0; address = '0; CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b0; LB = 1'b0;
    tb_data = '0; tb_drive = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wr_cnt", wr_cnt, 16'd0);
    check("rst_rd_cnt", rd_cnt, 16'd0);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_bus", data_bus, RELEASED);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic write then read-back.
    do_write(20'd5, 16'hA5C3, 1'b0, 1'b0);
    do_read("rd5", 20'd5, 16'hA5C3);
    check("basic_wr_cnt", wr_cnt, 16'd1);
    check("basic_rd_cnt", rd_cnt, 16'd1);

    // Byte lanes: upper only masked, lower only masked, both masked.
    do_write(20'd7, 16'h1234, 1'b0, 1'b0);
    do_write(20'd7, 16'hFFFF, 1'b1, 1'b0);
    do_read("lane_lo", 20'd7, 16'h12FF);
    do_write(20'd7, 16'hABCD, 1'b0, 1'b1);
    do_read("lane_hi", 20'd7, 16'hABFF);
    do_write(20'd7, 16'h0000, 1'b1, 1'b1);
    do_read("lane_none", 20'd7, 16'hABFF);
    check("lane_wr_cnt", wr_cnt, 16'd5);
    check("lane_rd_cnt", rd_cnt, 16'd4);

    // Write wins over a simultaneous OE; the block never drives.
    address = 20'd3; CE = 1'b0; OE = 1'b0; WE = 1'b0; tb_data = 16'h0042; tb_drive = 1'b1;
    @(negedge clk);
    check("wprio_bus", data_bus, 16'h0042);
    CE = 1'b1; OE = 1'b1; WE = 1'b1; tb_drive = 1'b0;
    seen_drive = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (data_bus !== RELEASED) seen_drive = 1'b1;
    end
    check("wprio_no_drive", seen_drive, 1'b0);
    check("wprio_rd_cnt", rd_cnt, 16'd4);
    check("wprio_wr_cnt", wr_cnt, 16'd6);
    do_read("wprio_rd", 20'd3, 16'h0042);

    // Out-of-range accesses: reads zero, write dropped without aliasing, flag sticks.
    check("oob_flag_pre", addr_err, 1'b0);
    do_read("oob_rd", 20'd1025, 16'h0000);
    check("oob_flag", addr_err, 1'b1);
    do_write(20'd1029, 16'h1111, 1'b0, 1'b0);
    do_read("oob_alias", 20'd5, 16'hA5C3);
    check("oob_flag_sticky", addr_err, 1'b1);
    check("oob_rd_cnt", rd_cnt, 16'd7);

    // Address change while driving re-fetches.
    start_read(20'd5, lat);
    check("achg_first", data_bus, 16'hA5C3);
    address = 20'd3;
    repeat (4) @(negedge clk);
    check("achg_refetch", data_bus, 16'h0042);
    CE = 1'b1; OE = 1'b1;
    repeat (2) @(negedge clk);

    // DRIVE -> WRITE releases the bus before the commit.
    start_read(20'd7, lat);
    check("d2w_first", data_bus, 16'hABFF);
    WE = 1'b0;
    @(negedge clk);
    check("d2w_release", data_bus, RELEASED);
    CE = 1'b1; OE = 1'b1; WE = 1'b1;
    repeat (2) @(negedge clk);
    check("d2w_wr_cnt", wr_cnt, 16'd7);
    do_read("d2w_rd", 20'd7, 16'hABFF);

    // Write counter saturation from a preset near the top.
    force dut.wr_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.wr_cnt_q;
    check("sat_preset", wr_cnt, 16'hFFFE);
    do_write(20'd9, 16'h0001, 1'b0, 1'b0);
    check("sat_first", wr_cnt, 16'hFFFF);
    do_write(20'd9, 16'h0002, 1'b0, 1'b0);
    do_write(20'd9, 16'h0003, 1'b0, 1'b0);
    check("sat_hold", wr_cnt, 16'hFFFF);

    // Async reset in the middle of a drive.
    start_read(20'd5, lat);
    check("rstd_drive", data_bus, 16'hA5C3);
    #2 reset_n = 1'b0;
    #1;
    check("rstd_bus", data_bus, RELEASED);
    check("rstd_wr_cnt", wr_cnt, 16'd0);
    check("rstd_rd_cnt", rd_cnt, 16'd0);
    check("rstd_addr_err", addr_err, 1'b0);
    @(negedge clk);
    // Strobe presented on the same edge reset is released.
    reset_n = 1'b1;
    do_write(20'd5, 16'h5A5A, 1'b0, 1'b0);
    do_read("post_rst_rd", 20'd5, 16'h5A5A);
    do_read("post_rst_init", 20'd7, 16'h0000);
    check("post_rst_wr_cnt", wr_cnt, 16'd1);
    check("post_rst_rd_cnt", rd_cnt, 16'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
